// File: rtl/conv_window_accum.sv
// Multiply-accumulate over one convolution window, then scale and saturate the
// sum to a 7-bit signed code. Optional rounding before the shift: CONV_ROUND_EN.
module conv_window_accum #(
    parameter int unsigned N_TAPS = 9,
    parameter int unsigned DW     = 4,
    parameter int unsigned ACC_W  = 12,
    parameter int unsigned SHIFT  = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] pixel,
    input  logic [DW-1:0] weight,
    output logic          res_flag,
    output logic [6:0]    res_value,
    input  logic          res_ready,
    output logic          sat
);

    localparam int unsigned PW = 2 * DW;
    localparam int unsigned CW = 4;
    localparam int unsigned SW = ACC_W + 1;

`ifdef CONV_ROUND_EN
    localparam logic signed [SW-1:0] RND = SW'((2 ** SHIFT) / 2);
`else
    localparam logic signed [SW-1:0] RND = SW'(0);
`endif
    localparam logic signed [SW-1:0] MAX_V = SW'(63);
    localparam logic signed [SW-1:0] MIN_V = SW'(-64);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SAT   = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic        [CW-1:0]     tap_q, tap_d;
    logic                     in_ready_q, in_ready_d;
    logic                     res_flag_q, res_flag_d;
    logic        [6:0]        res_value_q, res_value_d;
    logic                     sat_q, sat_d;

    logic signed [PW-1:0]     prod_c;
    logic signed [ACC_W-1:0]  prod_ext_c;
    logic signed [SW-1:0]     sum_c;
    logic signed [SW-1:0]     s_c;
    logic                     xfer_c;

    // Full-precision product, widened at SW bits so the rounding add cannot wrap.
    assign prod_c     = PW'($signed(pixel)) * PW'($signed(weight));
    assign prod_ext_c = ACC_W'(prod_c);
    assign sum_c      = SW'(acc_q) + RND;
    assign s_c        = sum_c >>> SHIFT;
    assign xfer_c     = in_valid && in_ready_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        tap_d       = tap_q;
        in_ready_d  = in_ready_q;
        res_flag_d  = res_flag_q;
        res_value_d = res_value_q;
        sat_d       = sat_q;

        unique case (state_q)
            IDLE: begin
                if (xfer_c) begin
                    acc_d = prod_ext_c;
                    tap_d = CW'(1);
                    if (N_TAPS == 1) begin
                        state_d    = SAT;
                        in_ready_d = 1'b0;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (xfer_c) begin
                    acc_d = acc_q + prod_ext_c;
                    tap_d = tap_q + CW'(1);
                    if (tap_q == CW'(N_TAPS - 1)) begin
                        state_d    = SAT;
                        in_ready_d = 1'b0;
                    end
                end
            end
            SAT: begin
                if (s_c > MAX_V) begin
                    res_value_d = 7'b0111111;
                    sat_d       = 1'b1;
                end else if (s_c < MIN_V) begin
                    res_value_d = 7'b1000000;
                    sat_d       = 1'b1;
                end else begin
                    res_value_d = s_c[6:0];
                    sat_d       = 1'b0;
                end
                res_flag_d = 1'b1;
                state_d    = OUT;
            end
            OUT: begin
                // Result held until downstream takes it; res_value is kept afterwards.
                if (res_ready) begin
                    res_flag_d = 1'b0;
                    sat_d      = 1'b0;
                    acc_d      = '0;
                    tap_d      = '0;
                    in_ready_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            tap_q       <= '0;
            in_ready_q  <= 1'b1;
            res_flag_q  <= 1'b0;
            res_value_q <= 7'd0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            tap_q       <= tap_d;
            in_ready_q  <= in_ready_d;
            res_flag_q  <= res_flag_d;
            res_value_q <= res_value_d;
            sat_q       <= sat_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign res_flag  = res_flag_q;
    assign res_value = res_value_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_conv_window_accum.sv
// Scoreboard bench: two instances (SHIFT=0 and SHIFT=2) share one input stream;
// a window-sum model predicts both results, checked by a negedge monitor.
module tb_conv_window_accum;

    localparam int unsigned N_TAPS = 9;
    localparam int unsigned DW     = 4;
    localparam int unsigned ACC_W  = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] pixel;
    logic [DW-1:0] weight;
    logic          res_ready;
    logic          in_ready_a, res_flag_a, sat_a;
    logic [6:0]    res_value_a;
    logic          in_ready_b, res_flag_b, sat_b;
    logic [6:0]    res_value_b;

    conv_window_accum #(.N_TAPS(N_TAPS), .DW(DW), .ACC_W(ACC_W), .SHIFT(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .pixel(pixel), .weight(weight), .res_flag(res_flag_a), .res_value(res_value_a),
        .res_ready(res_ready), .sat(sat_a)
    );

    conv_window_accum #(.N_TAPS(N_TAPS), .DW(DW), .ACC_W(ACC_W), .SHIFT(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .pixel(pixel), .weight(weight), .res_flag(res_flag_b), .res_value(res_value_b),
        .res_ready(res_ready), .sat(sat_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] va;
        logic       sa;
        logic [6:0] vb;
        logic       sb;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic rr_rand  = 1'b0;

    // model state
    int   cyc     = 0;
    int   due     = 0;
    int   tap_cnt = 0;
    int   win_sum = 0;
    logic pending = 1'b0;
    logic shown   = 1'b0;
    exp_t held    = '{7'd0, 1'b0, 7'd0, 1'b0};

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Reference result: window sum, optional round-half-up, floor shift, clip.
    function automatic logic [7:0] model(input int s, input int sh);
        int v;
        v = s;
`ifdef CONV_ROUND_EN
        if (sh > 0) v = v + (1 << (sh - 1));
`endif
        v = v >>> sh;
        if (v > 63)  return {1'b1, 7'h3F};
        if (v < -64) return {1'b1, 7'h40};
        return {1'b0, 7'(v)};
    endfunction

    always @(negedge clk) begin
        logic exp_flag;
        logic [7:0] ra, rb;
        exp_t e;
        cyc++;
        if (!rst_n) begin
            chk("rst_in_ready_a", 8'(in_ready_a), 8'd1);
            chk("rst_res_flag_a", 8'(res_flag_a), 8'd0);
            chk("rst_res_value_a", 8'(res_value_a), 8'd0);
            chk("rst_sat_a", 8'(sat_a), 8'd0);
            chk("rst_res_flag_b", 8'(res_flag_b), 8'd0);
            exp_q.delete();
            pending = 1'b0;
            shown   = 1'b0;
            tap_cnt = 0;
            win_sum = 0;
            held    = '{7'd0, 1'b0, 7'd0, 1'b0};
        end else begin
            exp_flag = pending && (cyc >= due);
            chk("in_ready_a", 8'(in_ready_a), 8'(!pending));
            chk("in_ready_b", 8'(in_ready_b), 8'(!pending));
            chk("res_flag_a", 8'(res_flag_a), 8'(exp_flag));
            chk("res_flag_b", 8'(res_flag_b), 8'(exp_flag));
            if (exp_flag && !shown) begin
                if (exp_q.size() == 0) begin
                    fail_timeout("scoreboard_empty");
                end else begin
                    held  = exp_q.pop_front();
                    shown = 1'b1;
                end
            end
            chk("res_value_a", 8'(res_value_a), 8'(held.va));
            chk("res_value_b", 8'(res_value_b), 8'(held.vb));
            chk("sat_a", 8'(sat_a), exp_flag ? 8'(held.sa) : 8'd0);
            chk("sat_b", 8'(sat_b), exp_flag ? 8'(held.sb) : 8'd0);
            // A pair offered now is taken on the next edge only if the window is open.
            if (in_valid && in_ready_a && !pending) begin
                win_sum += int'($signed(pixel)) * int'($signed(weight));
                tap_cnt++;
                if (tap_cnt == N_TAPS) begin
                    ra = model(win_sum, 0);
                    rb = model(win_sum, 2);
                    e = '{ra[6:0], ra[7], rb[6:0], rb[7]};
                    exp_q.push_back(e);
                    pending = 1'b1;
                    due     = cyc + 2;
                    tap_cnt = 0;
                    win_sum = 0;
                end
            end else if (exp_flag && res_ready) begin
                pending = 1'b0;
                shown   = 1'b0;
            end
        end
    end

    task automatic cyc_step();
        @(posedge clk);
        #1;
        if (rr_rand) res_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input int p, input int w);
        int n;
        n = 0;
        pixel    = DW'(p);
        weight   = DW'(w);
        in_valid = 1'b1;
        while (!in_ready_a && n < 100) begin
            cyc_step();
            n++;
        end
        if (n >= 100) fail_timeout("send_accept");
        cyc_step();
    endtask

    task automatic window_const(input int p, input int w);
        for (int i = 0; i < int'(N_TAPS); i++) send(p, w);
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while ((exp_q.size() != 0 || pending) && n < 200) begin
            cyc_step();
            n++;
        end
        if (n >= 200) fail_timeout("drain");
        cyc_step();
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        pixel     = '0;
        weight    = '0;
        res_ready = 1'b1;
        repeat (3) cyc_step();
        rst_n = 1'b1;
        cyc_step();

        // basic sums and both saturation limits, streamed back to back
        window_const(2, 3);
        window_const(7, 7);
        window_const(-8, 7);
        // +6 then -6: exercises the shifted instance's floor/rounding
        send(2, 3);
        for (int i = 1; i < int'(N_TAPS); i++) send(0, 0);
        send(2, -3);
        for (int i = 1; i < int'(N_TAPS); i++) send(0, 0);
        drain();

        // result held with res_ready low; in_valid pulses must be ignored
        res_ready = 1'b0;
        window_const(2, 3);
        in_valid = 1'b0;
        n = 0;
        while (!res_flag_a && n < 20) begin
            cyc_step();
            n++;
        end
        if (n >= 20) fail_timeout("hold_flag");
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            pixel    = 4'd7;
            weight   = 4'd7;
            cyc_step();
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        drain();

        // in_valid toggling every cycle
        for (int i = 0; i < int'(N_TAPS); i++) begin
            send(1, 1);
            in_valid = 1'b0;
            cyc_step();
        end
        drain();

        // reset mid-window discards the partial sum
        for (int i = 0; i < 4; i++) send(7, 7);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (3) cyc_step();
        rst_n = 1'b1;
        cyc_step();
        window_const(1, -1);
        drain();

        // random windows with gaps and random back-pressure
        rr_rand = 1'b1;
        for (int w = 0; w < 40; w++) begin
            for (int i = 0; i < int'(N_TAPS); i++) begin
                send(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
                if ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    repeat ($urandom_range(1, 2)) cyc_step();
                end
            end
        end
        rr_rand   = 1'b0;
        res_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
